// File: rtl/lc3_pipe_pkg.sv
// Shared opcode constants, encodings and instruction-class helpers for the
// LC-3 pipeline controller.
package lc3_pipe_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   localparam logic [1:0] MEM_READ     = 2'b00;
   localparam logic [1:0] MEM_READ_IND = 2'b01;
   localparam logic [1:0] MEM_WRITE    = 2'b10;
   localparam logic [1:0] MEM_IDLE     = 2'b11;

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EXEC = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef enum logic [1:0] {
      S_START = 2'b00,
      S_RUN   = 2'b01,
      S_MEM   = 2'b10,
      S_IND   = 2'b11
   } state_t;

   function automatic logic is_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
   endfunction

   function automatic logic writes_reg(input logic [3:0] op);
      return is_alu(op) || is_load(op);
   endfunction

endpackage

// File: rtl/lc3_fwd_unit.sv
// Combinational operand-forwarding selects and load-use hazard detection
// for the instruction sitting in DECODE.
module lc3_fwd_unit
   import lc3_pipe_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int REG_AW  = 3
) (
   input  logic [INSTR_W-1:0] ir_i,
   input  logic [INSTR_W-1:0] ir_exec_i,
   input  logic [INSTR_W-1:0] ir_mem_i,
   input  logic               valid_exec_i,
   input  logic               valid_mem_i,
   output logic [1:0]         fwd_sel_1_o,
   output logic [1:0]         fwd_sel_2_o,
   output logic               load_use_o
);

   localparam int OP_MSB  = INSTR_W - 1;
   localparam int DR_MSB  = INSTR_W - 5;
   localparam int SR1_MSB = DR_MSB - REG_AW;
   localparam int IMM_BIT = INSTR_W - 11;

   logic [3:0]        dec_op;
   logic [3:0]        exe_op;
   logic [3:0]        mem_op;
   logic [REG_AW-1:0] exe_dr;
   logic [REG_AW-1:0] mem_dr;
   logic              exe_can_fwd;
   logic              mem_can_fwd;
   logic              exe_is_load;

   logic [REG_AW-1:0] src   [2];
   logic              used  [2];
   logic [1:0]        sel   [2];
   logic              lu_hit[2];

   assign dec_op = ir_i[OP_MSB -: 4];
   assign exe_op = ir_exec_i[OP_MSB -: 4];
   assign mem_op = ir_mem_i[OP_MSB -: 4];
   assign exe_dr = ir_exec_i[DR_MSB -: REG_AW];
   assign mem_dr = ir_mem_i[DR_MSB -: REG_AW];

   // Only an ALU result exists at the end of EXECUTE; loads become forwardable from MEM.
   assign exe_can_fwd = valid_exec_i && is_alu(exe_op);
   assign mem_can_fwd = valid_mem_i && writes_reg(mem_op);
   assign exe_is_load = valid_exec_i && is_load(exe_op);

   assign src[0]  = ir_i[SR1_MSB -: REG_AW];
   assign used[0] = (dec_op == OP_ADD) || (dec_op == OP_AND) || (dec_op == OP_NOT) ||
                    (dec_op == OP_LDR) || (dec_op == OP_STR) || (dec_op == OP_JMP);

   // The second read port carries the store data register for stores.
   assign src[1]  = is_store(dec_op) ? ir_i[DR_MSB -: REG_AW] : ir_i[REG_AW-1:0];
   assign used[1] = (((dec_op == OP_ADD) || (dec_op == OP_AND)) && !ir_i[IMM_BIT]) ||
                    is_store(dec_op);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         always_comb begin
            sel[gi] = FWD_RF;
            if (used[gi] && exe_can_fwd && (exe_dr == src[gi])) begin
               sel[gi] = FWD_EXEC;
            end else if (used[gi] && mem_can_fwd && (mem_dr == src[gi])) begin
               sel[gi] = FWD_MEM;
            end
         end
         assign lu_hit[gi] = used[gi] && exe_is_load && (exe_dr == src[gi]);
      end
   endgenerate

   assign fwd_sel_1_o = sel[0];
   assign fwd_sel_2_o = sel[1];
   assign load_use_o  = lu_hit[0] || lu_hit[1];

   logic unused_bits;
   assign unused_bits = ^{ir_exec_i[SR1_MSB:0], ir_mem_i[SR1_MSB:0],
                          ir_i[IMM_BIT-1:REG_AW]};

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// Five-stage LC-3 pipeline controller: stage enables, forwarding, stalls,
// branch flush and LDI/STI memory sequencing. Optional LC3_PIPE_PERF_CNT_EN adds perf counters.
module lc3_pipe_ctrl
   import lc3_pipe_pkg::*;
#(
   parameter int INSTR_W     = 16,
   parameter int REG_AW      = 3,
   parameter int MEM_TIMEOUT = 31
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               complete_instr,
   input  logic               complete_data,
   input  logic [INSTR_W-1:0] IR,
   input  logic [INSTR_W-1:0] IR_Exec,
   input  logic [INSTR_W-1:0] IR_Mem,
   input  logic               valid_exec,
   input  logic               valid_mem,
   input  logic [2:0]         psr,
   output logic               enable_updatePC,
   output logic               enable_fetch,
   output logic               enable_decode,
   output logic               enable_execute,
   output logic               enable_writeback,
   output logic [1:0]         fwd_sel_1,
   output logic [1:0]         fwd_sel_2,
   output logic [1:0]         mem_state,
   output logic               br_taken,
   output logic               flush,
   output logic               stall,
   output logic               mem_timeout_err
`ifdef LC3_PIPE_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cycles,
   output logic [15:0]        flush_count
`endif
);

   localparam int CNT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int OP_MSB = INSTR_W - 1;
   localparam int CC_MSB = INSTR_W - 5;

   state_t            state_q, state_d;
   logic [1:0]        mem_state_q, mem_state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;

   logic [3:0]        exe_op;
   logic [3:0]        mem_op;
   logic              mem_is_ls;
   logic              br_cond;
   logic              load_use;
   logic [1:0]        fwd1_w, fwd2_w;

   logic              en_upc, en_fetch, en_dec, en_exe, en_wb;
   logic              br_o, flush_o, stall_o;

   lc3_fwd_unit #(
      .INSTR_W (INSTR_W),
      .REG_AW  (REG_AW)
   ) u_fwd (
      .ir_i         (IR),
      .ir_exec_i    (IR_Exec),
      .ir_mem_i     (IR_Mem),
      .valid_exec_i (valid_exec),
      .valid_mem_i  (valid_mem),
      .fwd_sel_1_o  (fwd1_w),
      .fwd_sel_2_o  (fwd2_w),
      .load_use_o   (load_use)
   );

   assign exe_op    = IR_Exec[OP_MSB -: 4];
   assign mem_op    = IR_Mem[OP_MSB -: 4];
   assign mem_is_ls = valid_mem && (is_load(mem_op) || is_store(mem_op));
   assign br_cond   = valid_exec &&
                      (((exe_op == OP_BR) && |(IR_Exec[CC_MSB -: 3] & psr)) ||
                       (exe_op == OP_JMP));

   always_comb begin
      state_d     = state_q;
      mem_state_d = mem_state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      done_d      = done_q;
      en_upc      = 1'b0;
      en_fetch    = 1'b0;
      en_dec      = 1'b0;
      en_exe      = 1'b0;
      en_wb       = 1'b0;
      br_o        = 1'b0;
      flush_o     = 1'b0;
      stall_o     = 1'b0;

      unique case (state_q)
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            en_fetch = 1'b1;
            // done_q marks the access already serviced for the op still held in MEM.
            if (mem_is_ls && !done_q) begin
               stall_o     = 1'b1;
               state_d     = S_MEM;
               mem_state_d = (is_store(mem_op) && (mem_op != OP_STI)) ? MEM_WRITE : MEM_READ;
            end else begin
               en_exe = 1'b1;
               en_wb  = 1'b1;
               done_d = 1'b0;
               if (br_cond) begin
                  br_o    = 1'b1;
                  flush_o = 1'b1;
                  en_upc  = 1'b1;
               end else if (load_use) begin
                  stall_o = 1'b1;
               end else begin
                  en_upc = complete_instr;
                  en_dec = complete_instr;
               end
            end
         end
         S_MEM, S_IND: begin
            en_fetch = 1'b1;
            stall_o  = 1'b1;
            if (complete_data) begin
               if ((state_q == S_MEM) && (mem_op == OP_LDI)) begin
                  state_d     = S_IND;
                  mem_state_d = MEM_READ_IND;
               end else if ((state_q == S_MEM) && (mem_op == OP_STI)) begin
                  state_d     = S_IND;
                  mem_state_d = MEM_WRITE;
               end else begin
                  state_d     = S_RUN;
                  mem_state_d = MEM_IDLE;
                  done_d      = 1'b1;
               end
            end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
               err_d       = 1'b1;
               state_d     = S_RUN;
               mem_state_d = MEM_IDLE;
               done_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_START;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_START;
         mem_state_q <= MEM_IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_state_q <= mem_state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   assign enable_updatePC  = en_upc   && !reset;
   assign enable_fetch     = en_fetch && !reset;
   assign enable_decode    = en_dec   && !reset;
   assign enable_execute   = en_exe   && !reset;
   assign enable_writeback = en_wb    && !reset;
   assign br_taken         = br_o     && !reset;
   assign flush            = flush_o  && !reset;
   assign stall            = stall_o  && !reset;
   assign fwd_sel_1        = reset ? FWD_RF : fwd1_w;
   assign fwd_sel_2        = reset ? FWD_RF : fwd2_w;
   assign mem_state        = mem_state_q;
   assign mem_timeout_err  = err_q;

`ifdef LC3_PIPE_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (flush && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed self-checking bench for lc3_pipe_ctrl: reset, forwarding, load-use,
// branch, LDI/STI sequencing and memory timeout.
module tb_lc3_pipe_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        complete_instr;
   logic        complete_data;
   logic [15:0] IR, IR_Exec, IR_Mem;
   logic        valid_exec, valid_mem;
   logic [2:0]  psr;
   logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
   logic [1:0]  fwd_sel_1, fwd_sel_2, mem_state;
   logic        br_taken, flush, stall, mem_timeout_err;
`ifdef LC3_PIPE_PERF_CNT_EN
   logic [15:0] stall_cycles, flush_count;
`endif

   int checks   = 0;
   int failures = 0;

   lc3_pipe_ctrl dut (
      .clock            (clock),
      .reset            (reset),
      .complete_instr   (complete_instr),
      .complete_data    (complete_data),
      .IR               (IR),
      .IR_Exec          (IR_Exec),
      .IR_Mem           (IR_Mem),
      .valid_exec       (valid_exec),
      .valid_mem        (valid_mem),
      .psr              (psr),
      .enable_updatePC  (enable_updatePC),
      .enable_fetch     (enable_fetch),
      .enable_decode    (enable_decode),
      .enable_execute   (enable_execute),
      .enable_writeback (enable_writeback),
      .fwd_sel_1        (fwd_sel_1),
      .fwd_sel_2        (fwd_sel_2),
      .mem_state        (mem_state),
      .br_taken         (br_taken),
      .flush            (flush),
      .stall            (stall),
      .mem_timeout_err  (mem_timeout_err)
`ifdef LC3_PIPE_PERF_CNT_EN
      ,
      .stall_cycles     (stall_cycles),
      .flush_count      (flush_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   localparam logic [15:0] ADD_R3_R1_R2 = 16'h1642;
   localparam logic [15:0] ADD_R4_R3_R3 = 16'h18C3;
   localparam logic [15:0] LDR_R2_R6_0  = 16'h6580;
   localparam logic [15:0] AND_R5_R2_1  = 16'h5AA1;
   localparam logic [15:0] BRZ          = 16'h0405;
   localparam logic [15:0] JMP_R7       = 16'hC1C0;
   localparam logic [15:0] LD_R1        = 16'h2200;
   localparam logic [15:0] LDI_R1       = 16'hA200;
   localparam logic [15:0] STI_R1       = 16'hB200;
   localparam logic [15:0] ST_R1        = 16'h3200;

   initial begin
      reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0;
      IR = '0; IR_Exec = '0; IR_Mem = '0; valid_exec = 1'b0; valid_mem = 1'b0; psr = 3'b000;

      // Reset held three cycles, with a forwarding pattern present that must be masked.
      nxt();
      IR = ADD_R4_R3_R3; IR_Exec = ADD_R3_R1_R2; valid_exec = 1'b1; #1;
      chk("rst_fetch", {15'd0, enable_fetch}, 16'd0);
      chk("rst_stall", {15'd0, stall}, 16'd0);
      chk("rst_mem_state", {14'd0, mem_state}, 16'd3);
      chk("rst_fwd1", {14'd0, fwd_sel_1}, 16'd0);
      nxt();
      nxt();
      reset = 1'b0; IR = '0; IR_Exec = '0; valid_exec = 1'b0; #1;
      chk("start_fetch", {15'd0, enable_fetch}, 16'd0);
      chk("start_exec", {15'd0, enable_execute}, 16'd0);

      nxt();
      chk("run_fetch", {15'd0, enable_fetch}, 16'd1);
      chk("run_mem_state", {14'd0, mem_state}, 16'd3);
      chk("run_fwd1", {14'd0, fwd_sel_1}, 16'd0);
      chk("run_fwd2", {14'd0, fwd_sel_2}, 16'd0);
      chk("run_upc_noinstr", {15'd0, enable_updatePC}, 16'd0);
      chk("run_dec_noinstr", {15'd0, enable_decode}, 16'd0);
      chk("run_exec_noinstr", {15'd0, enable_execute}, 16'd1);
      complete_instr = 1'b1; #1;
      chk("run_upc", {15'd0, enable_updatePC}, 16'd1);
      chk("run_dec", {15'd0, enable_decode}, 16'd1);
      chk("run_wb", {15'd0, enable_writeback}, 16'd1);

      // Forwarding from EXECUTE, from MEM, and EXECUTE priority.
      nxt();
      IR = ADD_R4_R3_R3; IR_Exec = ADD_R3_R1_R2; valid_exec = 1'b1; #1;
      chk("fwd_exec_1", {14'd0, fwd_sel_1}, 16'd1);
      chk("fwd_exec_2", {14'd0, fwd_sel_2}, 16'd1);
      chk("fwd_exec_nostall", {15'd0, stall}, 16'd0);
      valid_exec = 1'b0; IR_Exec = '0; IR_Mem = ADD_R3_R1_R2; valid_mem = 1'b1; #1;
      chk("fwd_mem_1", {14'd0, fwd_sel_1}, 16'd2);
      chk("fwd_mem_2", {14'd0, fwd_sel_2}, 16'd2);
      IR_Exec = ADD_R3_R1_R2; valid_exec = 1'b1; #1;
      chk("fwd_prio_1", {14'd0, fwd_sel_1}, 16'd1);

      // Load-use: LDR R2 in EXECUTE, AND R5,R2,#1 in DECODE.
      nxt();
      valid_mem = 1'b0; IR_Mem = '0; IR_Exec = LDR_R2_R6_0; valid_exec = 1'b1; IR = AND_R5_R2_1; #1;
      chk("lu_stall", {15'd0, stall}, 16'd1);
      chk("lu_dec", {15'd0, enable_decode}, 16'd0);
      chk("lu_upc", {15'd0, enable_updatePC}, 16'd0);
      chk("lu_exec", {15'd0, enable_execute}, 16'd1);
      chk("lu_fwd1", {14'd0, fwd_sel_1}, 16'd0);
      chk("lu_fwd2", {14'd0, fwd_sel_2}, 16'd0);
      nxt();
      valid_exec = 1'b0; IR_Exec = '0; IR_Mem = LDR_R2_R6_0; valid_mem = 1'b1; #1;
      chk("lu_next_fwd1", {14'd0, fwd_sel_1}, 16'd2);
      chk("ldr_enter_stall", {15'd0, stall}, 16'd1);
      chk("ldr_enter_exec", {15'd0, enable_execute}, 16'd0);
      chk("ldr_enter_mem_state", {14'd0, mem_state}, 16'd3);
      nxt();
      chk("ldr_mem_state", {14'd0, mem_state}, 16'd0);
      chk("ldr_fetch", {15'd0, enable_fetch}, 16'd1);
      chk("ldr_stall", {15'd0, stall}, 16'd1);
      complete_data = 1'b1;
      nxt();
      complete_data = 1'b0; #1;
      chk("ldr_done_mem_state", {14'd0, mem_state}, 16'd3);
      chk("ldr_done_stall", {15'd0, stall}, 16'd0);
      chk("ldr_done_exec", {15'd0, enable_execute}, 16'd1);
      valid_mem = 1'b0; IR_Mem = '0;

      // Branch resolution.
      nxt();
      IR = '0; IR_Exec = BRZ; valid_exec = 1'b1; psr = 3'b010; #1;
      chk("brz_taken", {15'd0, br_taken}, 16'd1);
      chk("brz_flush", {15'd0, flush}, 16'd1);
      chk("brz_upc", {15'd0, enable_updatePC}, 16'd1);
      psr = 3'b100; #1;
      chk("brz_nt_taken", {15'd0, br_taken}, 16'd0);
      chk("brz_nt_flush", {15'd0, flush}, 16'd0);
      IR_Exec = JMP_R7; #1;
      chk("jmp_taken", {15'd0, br_taken}, 16'd1);
      valid_exec = 1'b0; #1;
      chk("jmp_bubble", {15'd0, br_taken}, 16'd0);

      // Branch deferred while a memory access begins.
      nxt();
      valid_exec = 1'b1; IR_Mem = LD_R1; valid_mem = 1'b1; #1;
      chk("defer_br", {15'd0, br_taken}, 16'd0);
      chk("defer_stall", {15'd0, stall}, 16'd1);
      nxt();
      chk("ld_mem_state", {14'd0, mem_state}, 16'd0);
      chk("ld_br_held", {15'd0, br_taken}, 16'd0);
      complete_data = 1'b1;
      nxt();
      complete_data = 1'b0; #1;
      chk("defer_br_resume", {15'd0, br_taken}, 16'd1);
      chk("defer_flush_resume", {15'd0, flush}, 16'd1);
      valid_exec = 1'b0; IR_Exec = '0; valid_mem = 1'b0; IR_Mem = '0;

      // LDI: complete after 3 cycles in the first access, 2 in the indirect one.
      nxt();
      IR_Mem = LDI_R1; valid_mem = 1'b1; #1;
      chk("ldi_enter_stall", {15'd0, stall}, 16'd1);
      nxt();
      chk("ldi_c1_mem_state", {14'd0, mem_state}, 16'd0);
      nxt();
      chk("ldi_c2_stall", {15'd0, stall}, 16'd1);
      nxt();
      complete_data = 1'b1; #1;
      chk("ldi_c3_mem_state", {14'd0, mem_state}, 16'd0);
      nxt();
      complete_data = 1'b0; #1;
      chk("ldi_ind_mem_state", {14'd0, mem_state}, 16'd1);
      chk("ldi_ind_stall", {15'd0, stall}, 16'd1);
      nxt();
      complete_data = 1'b1; #1;
      chk("ldi_ind2_mem_state", {14'd0, mem_state}, 16'd1);
      nxt();
      complete_data = 1'b0; #1;
      chk("ldi_done_mem_state", {14'd0, mem_state}, 16'd3);
      chk("ldi_done_stall", {15'd0, stall}, 16'd0);
      valid_mem = 1'b0; IR_Mem = '0;

      // STI: read pointer first, then write.
      nxt();
      IR_Mem = STI_R1; valid_mem = 1'b1;
      nxt();
      chk("sti_mem_state", {14'd0, mem_state}, 16'd0);
      complete_data = 1'b1;
      nxt();
      complete_data = 1'b0; #1;
      chk("sti_ind_mem_state", {14'd0, mem_state}, 16'd2);
      complete_data = 1'b1;
      nxt();
      complete_data = 1'b0; #1;
      chk("sti_done_mem_state", {14'd0, mem_state}, 16'd3);
      valid_mem = 1'b0; IR_Mem = '0;

      // ST with no completion: timeout after 31 cycles in the access state.
      nxt();
      IR_Mem = ST_R1; valid_mem = 1'b1; #1;
      chk("to_err_before", {15'd0, mem_timeout_err}, 16'd0);
      nxt();
      chk("st_mem_state", {14'd0, mem_state}, 16'd2);
      for (int i = 0; i < 30; i++) nxt();
      chk("to_err_c31", {15'd0, mem_timeout_err}, 16'd0);
      chk("to_mem_state_c31", {14'd0, mem_state}, 16'd2);
      chk("to_stall_c31", {15'd0, stall}, 16'd1);
      nxt();
      chk("to_err_set", {15'd0, mem_timeout_err}, 16'd1);
      chk("to_mem_state_idle", {14'd0, mem_state}, 16'd3);
      chk("to_stall_released", {15'd0, stall}, 16'd0);
      valid_mem = 1'b0; IR_Mem = '0;
      nxt();
      nxt();
      nxt();
      chk("to_err_sticky", {15'd0, mem_timeout_err}, 16'd1);
      reset = 1'b1;
      nxt();
      chk("to_err_cleared", {15'd0, mem_timeout_err}, 16'd0);
      chk("rst_again_fetch", {15'd0, enable_fetch}, 16'd0);
      reset = 1'b0;
      nxt();
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
